dispatcher_ctrl: RTL and testbench

Sequencer for the Stripes dispatcher's double-buffered transposer arrays. Per brick-set it drives per-window brick selects, per-row transposer selects and per-window write enables into one buffer while the other buffer drains bit-serially, then swaps buffers. It sits between the activation memory read port (valid/ready handshake) and the dispatcher's control inputs, and flags which dispatcher output cycles carry valid serial data.

---
 rtl/dispatcher_ctrl.sv | 123 ++++++++++++
 tb/tb_dispatcher_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher_ctrl.sv
// dispatcher_ctrl: sequences double-buffered transposer loads and bit-serial drains
// for the Stripes dispatcher, one brick-set per buffer swap.
module dispatcher_ctrl #(
  parameter int WL               = 16,
  parameter int WORDS_PER_BRICK  = 16,
  parameter int PARALLEL_WINDOWS = 16,
  parameter int SEL_BITS         = 4,
  parameter int PREC_BITS        = 5,
  parameter int STREAM_LAT       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [15:0]                          i_num_sets,
  input  logic [PREC_BITS-1:0]                 i_precision,
  input  logic [PARALLEL_WINDOWS-1:0]          i_win_mask,
  input  logic [SEL_BITS*PARALLEL_WINDOWS-1:0] i_brick_sel,
  input  logic                                 i_mem_valid,
  output logic                                 o_mem_ready,
  output logic [SEL_BITS*PARALLEL_WINDOWS-1:0] o_sel,
  output logic [SEL_BITS-1:0]                  o_sel_t,
  output logic [PARALLEL_WINDOWS-1:0]          o_enable,
  output logic                                 o_read_buf,
  output logic                                 o_stream_valid,
  output logic                                 o_busy,
  output logic                                 o_done
);
  localparam int LD_W = $clog2(WORDS_PER_BRICK + 1);
  localparam logic [LD_W-1:0] full_cnt = LD_W'(WORDS_PER_BRICK);
  localparam logic [LD_W-1:0] last_row = LD_W'(WORDS_PER_BRICK - 1);
  localparam logic [PREC_BITS-1:0] max_prec = PREC_BITS'(WL);
  localparam logic [STREAM_LAT-1:0] last_bit = STREAM_LAT'(1) << (STREAM_LAT - 1);

  typedef enum logic [2:0] {IDLE, FILL, STEADY, DRAIN, DONE} state_t;

  state_t state, state_n;
  logic [15:0] num, num_n, ld_sets, ld_sets_n, drained, drained_n;
  logic [PREC_BITS-1:0] prec, prec_n, prec_in, dr_cnt, dr_cnt_n;
  logic [PARALLEL_WINDOWS-1:0] mask;
  logic [SEL_BITS*PARALLEL_WINDOWS-1:0] bsel;
  logic [LD_W-1:0] ld_cnt, ld_cnt_n, row;
  logic [STREAM_LAT-1:0] pipe, pipe_n;
  logic dr_act, dr_act_n;
  logic run, start, acc, swap, drain_now, fin, load_n, swap_n, ready_n, busy_n;

  assign o_stream_valid = pipe[STREAM_LAT-1];

  always_comb begin
    run       = state inside {FILL, STEADY, DRAIN};
    start     = state == IDLE && i_start;
    prec_in   = (i_precision == '0 || i_precision > max_prec) ? max_prec : i_precision;
    num_n     = start ? i_num_sets : num;
    prec_n    = start ? prec_in : prec;
    acc       = i_mem_valid && o_mem_ready;
    swap      = run && ld_cnt == full_cnt && (!dr_act || dr_cnt == prec);
    row       = swap ? '0 : ld_cnt;
    drain_now = swap || (run && dr_act && dr_cnt < prec);
    ld_cnt_n  = start ? '0 : swap ? LD_W'(acc) : ld_cnt + LD_W'(acc);
    ld_sets_n = start ? '0 : ld_sets + 16'(acc && row == last_row);
    dr_act_n  = !start && (dr_act || swap);
    // dr_cnt counts bit-planes already issued; the swap cycle issues plane 0
    dr_cnt_n  = start ? '0 : swap ? PREC_BITS'(1) : dr_cnt + PREC_BITS'(drain_now);
    pipe_n    = start ? '0 : (pipe << 1) | STREAM_LAT'(drain_now);
    drained_n = start ? '0 : drained + 16'(drain_now && dr_cnt_n == prec);
    fin       = drained_n == num && pipe_n == last_bit;
    state_n   = start ? ((i_num_sets == '0) ? DONE : FILL) :
                state == DONE ? IDLE :
                !run ? state :
                fin ? DONE :
                swap ? ((ld_sets < num) ? STEADY : DRAIN) : state;
    load_n    = state_n inside {FILL, STEADY};
    // predict next cycle's swap so ready stays high across it at full rate
    swap_n    = ld_cnt_n == full_cnt && (!dr_act_n || dr_cnt_n == prec_n);
    ready_n   = load_n && ld_sets_n < num_n && (ld_cnt_n != full_cnt || swap_n);
    busy_n    = (state_n inside {FILL, STEADY, DRAIN}) || (state_n == DONE && state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      num         <= '0;
      prec        <= '0;
      mask        <= '0;
      bsel        <= '0;
      ld_cnt      <= '0;
      ld_sets     <= '0;
      dr_act      <= 1'b0;
      dr_cnt      <= '0;
      drained     <= '0;
      pipe        <= '0;
      o_mem_ready <= 1'b0;
      o_sel       <= '0;
      o_sel_t     <= '0;
      o_enable    <= '0;
      o_read_buf  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_n;
      num         <= num_n;
      prec        <= prec_n;
      if (start) begin
        mask <= i_win_mask;
        bsel <= i_brick_sel;
      end
      ld_cnt      <= ld_cnt_n;
      ld_sets     <= ld_sets_n;
      dr_act      <= dr_act_n;
      dr_cnt      <= dr_cnt_n;
      drained     <= drained_n;
      pipe        <= pipe_n;
      o_mem_ready <= ready_n;
      o_enable    <= acc ? mask : '0;
      if (acc) begin
        o_sel_t <= row[SEL_BITS-1:0];
        o_sel   <= bsel;
      end
      o_read_buf  <= o_read_buf ^ swap;
      o_busy      <= busy_n;
      o_done      <= state == DONE;
    end
  end
endmodule

// File: tb/tb_dispatcher_ctrl.sv
// tb_dispatcher_ctrl: randomized scoreboard bench; an event-level schedule model
// predicts accepts, swaps, stream cycles and done, and a monitor pops and compares.
module tb_dispatcher_ctrl;
  localparam int LAT  = 2;
  localparam int MAXC = 1024;

  logic        clk, rst_n, i_start, i_mem_valid;
  logic [15:0] i_num_sets;
  logic [4:0]  i_precision;
  logic [15:0] i_win_mask;
  logic [63:0] i_brick_sel;
  logic        o_mem_ready, o_read_buf, o_stream_valid, o_busy, o_done;
  logic [63:0] o_sel;
  logic [3:0]  o_sel_t;
  logic [15:0] o_enable;

  dispatcher_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_sets(i_num_sets),
    .i_precision(i_precision), .i_win_mask(i_win_mask), .i_brick_sel(i_brick_sel),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready), .o_sel(o_sel),
    .o_sel_t(o_sel_t), .o_enable(o_enable), .o_read_buf(o_read_buf),
    .o_stream_valid(o_stream_valid), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {int c; int row;} en_t;
  en_t en_q[$];
  int  sv_q[$], tg_q[$], done_q[$];
  bit  vld[MAXC];
  bit  exp_ready[MAXC];
  int  exp_done, exp_n, base;
  int  tick = 0;
  int  checks = 0, failures = 0;
  bit  active = 0;
  logic rb_prev;
  logic [15:0] cur_mask;
  logic [63:0] cur_bsel;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tick - base);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d", name, tick - base);
  endtask

  // Schedule model: each set loads WORDS_PER_BRICK accepted rows, swaps once both its
  // load is finished and the previous set has issued all P bit-planes, then drains P cycles.
  task automatic plan(input int n, input int p_raw);
    int p, ls, c, rows, sw, dend;
    p = (p_raw == 0 || p_raw > 16) ? 16 : p_raw;
    exp_n = n;
    ls = 1;
    dend = 0;
    if (n == 0) begin
      exp_done = 2;
      done_q.push_back(2);
      return;
    end
    for (int k = 0; k < n; k++) begin
      c = ls;
      rows = 0;
      while (rows < 16 && c < MAXC - 8) begin
        exp_ready[c] = 1;
        if (vld[c]) begin
          en_q.push_back(en_t'{c + 1, rows});
          rows++;
        end
        c++;
      end
      sw = c;
      if (k > 0 && dend + 1 > sw) sw = dend + 1;
      tg_q.push_back(sw + 1);
      for (int d = 0; d < p; d++) sv_q.push_back(sw + d + LAT);
      dend = sw + p - 1;
      ls = sw;
    end
    exp_done = dend + LAT + 1;
    done_q.push_back(exp_done);
  endtask

  always @(negedge clk) begin
    int rc;
    en_t e;
    if (active) begin
      rc = tick - base;
      if (rc >= 0 && rc < MAXC) begin
        chk("mem_ready", o_mem_ready, exp_ready[rc]);
        chk("busy", o_busy, exp_n > 0 && rc >= 1 && rc < exp_done);
      end
      if (o_enable != 0) begin
        if (en_q.size() == 0) unexpected("enable");
        else begin
          e = en_q.pop_front();
          chk("enable_cycle", rc, e.c);
          chk("sel_t", o_sel_t, e.row);
          chk("enable_mask", o_enable, cur_mask);
          chk("sel", o_sel, cur_bsel);
        end
      end
      if (o_stream_valid) begin
        if (sv_q.size() == 0) unexpected("stream_valid");
        else chk("stream_cycle", rc, sv_q.pop_front());
      end
      if (o_read_buf !== rb_prev) begin
        rb_prev = o_read_buf;
        if (tg_q.size() == 0) unexpected("read_buf_toggle");
        else chk("toggle_cycle", rc, tg_q.pop_front());
      end
      if (o_done) begin
        if (done_q.size() == 0) unexpected("done");
        else chk("done_cycle", rc, done_q.pop_front());
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    chk(name, {o_mem_ready, o_sel, o_sel_t, o_enable, o_read_buf, o_stream_valid, o_busy, o_done}, '0);
  endtask

  // mode 0: memory always valid; 1: 5-cycle gap mid-load; 2: random valid
  task automatic run(input int n, input int p, input int mode, input bit busy_start, input int rst_at);
    en_q.delete(); sv_q.delete(); tg_q.delete(); done_q.delete();
    for (int c = 0; c < MAXC; c++) begin
      vld[c] = (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 8 && c < 13) : ($urandom_range(0, 3) != 0);
      exp_ready[c] = 0;
    end
    cur_mask = 16'($urandom_range(1, 65535));
    cur_bsel = {$urandom, $urandom};
    plan(n, p);
    @(negedge clk);
    base        = tick;
    i_start     = 1;
    i_num_sets  = 16'(n);
    i_precision = 5'(p);
    i_win_mask  = cur_mask;
    i_brick_sel = cur_bsel;
    i_mem_valid = vld[0];
    rb_prev     = o_read_buf;
    active      = 1;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      i_start     = busy_start && c == 4;
      i_num_sets  = 16'($urandom_range(0, 9));
      i_precision = 5'($urandom);
      i_win_mask  = 16'($urandom);
      i_brick_sel = {$urandom, $urandom};
      i_mem_valid = vld[c];
      if (c == rst_at) begin
        active = 0;
        rst_n  = 0;
        @(negedge clk);
        rst_n  = 1;
        check_idle_outputs("midrun_reset_outputs");
        repeat (30) begin
          @(negedge clk);
          chk("no_done_after_reset", {o_done, o_busy, o_enable}, '0);
        end
        return;
      end
    end
    active = 0;
    i_start = 0;
    chk("enables_left", en_q.size(), 0);
    chk("stream_left", sv_q.size(), 0);
    chk("toggles_left", tg_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  initial begin
    rst_n = 0; i_start = 1; i_mem_valid = 1;
    i_num_sets = 16'd3; i_precision = 5'd8; i_win_mask = '1; i_brick_sel = '1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    chk("reset_read_buf", o_read_buf, 0);
    @(negedge clk);
    check_idle_outputs("reset_outputs_hold");
    rst_n = 1; i_start = 0; i_mem_valid = 0;
    @(negedge clk);
    run(1, 16, 0, 0, 0);
    run(3, 8, 0, 1, 0);
    run(2, 0, 1, 0, 0);
    run(0, 5, 0, 0, 0);
    run(3, 8, 0, 0, 25);
    run(1, 16, 0, 0, 0);
    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 4), $urandom_range(0, 31), 2, 1'($urandom), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
